// File: rtl/ipg_tx_frame_arbiter_if.sv
// rtl/ipg_tx_frame_arbiter_if.sv - requester and MAC-side stream bundle for the tx frame arbiter
interface ipg_tx_frame_arbiter_if #(
    parameter int N_PORTS    = 2,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
    logic [N_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [N_PORTS-1:0]            s_axis_tvalid;
    logic [N_PORTS-1:0]            s_axis_tready;
    logic [N_PORTS-1:0]            s_axis_tlast;

    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;

    // Arbiter side: sinks the requester streams, sources the MAC stream.
    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/ipg_tx_frame_arbiter.sv
// rtl/ipg_tx_frame_arbiter.sv - frame-granular round-robin arbiter feeding one MAC tx stream
module ipg_tx_frame_arbiter #(
    parameter int N_PORTS        = 2,
    parameter int DATA_WIDTH     = 64,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int PRIORITY_PORT0 = 0,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                    tx_clk,
    input  logic                    tx_rst_n,
    ipg_tx_frame_arbiter_if.slave   axis,
    input  logic                    arb_enable,
    output logic [N_PORTS-1:0]      arb_grant,
    output logic                    arb_busy,
    output logic [N_PORTS-1:0]      frame_done
);
    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW    = IDX_W + 1;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t               state_q, state_d;
    logic [N_PORTS-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]           starve_cnt_q, starve_cnt_d;
    logic [N_PORTS-1:0]   frame_done_q, frame_done_d;

    logic [N_PORTS-1:0]   req_mask;
    logic                 others_valid;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [CW-1:0]        cand;

    assign others_valid = (axis.s_axis_tvalid & ~N_PORTS'(1)) != '0;

    always_comb begin : win_sel
        req_mask  = axis.s_axis_tvalid;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        // Port 0 is only locked out while it has starved someone else.
        if (PRIORITY_PORT0 != 0 && starve_cnt_q >= 8'(STARVE_LIMIT) && others_valid) begin
            req_mask[0] = 1'b0;
        end
        if (PRIORITY_PORT0 != 0 && axis.s_axis_tvalid[0] && starve_cnt_q < 8'(STARVE_LIMIT)) begin
            win_found = 1'b1;
            win_idx   = '0;
        end else begin
            for (int k = 0; k < N_PORTS; k++) begin
                cand = {1'b0, rr_ptr_q} + CW'(k);
                if (cand >= CW'(N_PORTS)) begin
                    cand = cand - CW'(N_PORTS);
                end
                if (!win_found && req_mask[cand[IDX_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = cand[IDX_W-1:0];
                end
            end
        end
    end

    always_comb begin : fsm_next
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        rr_ptr_d     = rr_ptr_q;
        starve_cnt_d = starve_cnt_q;
        frame_done_d = '0;

        axis.m_axis_tdata  = '0;
        axis.m_axis_tkeep  = '0;
        axis.m_axis_tvalid = 1'b0;
        axis.m_axis_tlast  = 1'b0;
        axis.s_axis_tready = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_enable && win_found) begin
                    state_d = ST_ACTIVE;
                    grant_d = N_PORTS'(1) << win_idx;
                    gidx_d  = win_idx;
                    if (win_idx == '0 && others_valid) begin
                        if (starve_cnt_q < 8'(STARVE_LIMIT)) begin
                            starve_cnt_d = starve_cnt_q + 8'd1;
                        end
                    end else begin
                        starve_cnt_d = '0;
                    end
                end
            end
            ST_ACTIVE: begin
                // Zero-latency pass-through of the granted port.
                for (int i = 0; i < N_PORTS; i++) begin
                    if (grant_q[i]) begin
                        axis.m_axis_tdata  = axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                        axis.m_axis_tkeep  = axis.s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                        axis.m_axis_tvalid = axis.s_axis_tvalid[i];
                        axis.m_axis_tlast  = axis.s_axis_tlast[i];
                    end
                end
                axis.s_axis_tready = grant_q & {N_PORTS{axis.m_axis_tready}};
                if (axis.m_axis_tvalid && axis.m_axis_tready && axis.m_axis_tlast) begin
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    frame_done_d = grant_q;
                    rr_ptr_d     = (gidx_q == IDX_W'(N_PORTS - 1)) ? '0 : gidx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            rr_ptr_q     <= '0;
            starve_cnt_q <= '0;
            frame_done_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            rr_ptr_q     <= rr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign arb_grant  = grant_q;
    assign arb_busy   = (state_q == ST_ACTIVE);
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_ipg_tx_frame_arbiter.sv
// tb/tb_ipg_tx_frame_arbiter.sv - directed self-checking bench for ipg_tx_frame_arbiter
module tb_ipg_tx_frame_arbiter;
    localparam int NP = 3;
    localparam int DW = 16;
    localparam int KW = 2;

    logic tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    logic              tx_rst_n;
    logic              arb_enable;
    logic              m_tready;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;

    logic [NP-1:0] grant_rr, done_rr, grant_pr, done_pr;
    logic          busy_rr, busy_pr;

    ipg_tx_frame_arbiter_if #(.N_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) if_rr ();
    ipg_tx_frame_arbiter_if #(.N_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) if_pr ();

    assign if_rr.s_axis_tdata  = s_tdata;
    assign if_rr.s_axis_tkeep  = s_tkeep;
    assign if_rr.s_axis_tvalid = s_tvalid;
    assign if_rr.s_axis_tlast  = s_tlast;
    assign if_rr.m_axis_tready = m_tready;
    assign if_pr.s_axis_tdata  = s_tdata;
    assign if_pr.s_axis_tkeep  = s_tkeep;
    assign if_pr.s_axis_tvalid = s_tvalid;
    assign if_pr.s_axis_tlast  = s_tlast;
    assign if_pr.m_axis_tready = m_tready;

    ipg_tx_frame_arbiter #(
        .N_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .PRIORITY_PORT0(0), .STARVE_LIMIT(4)
    ) dut_rr (
        .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .axis(if_rr.slave), .arb_enable(arb_enable),
        .arb_grant(grant_rr), .arb_busy(busy_rr), .frame_done(done_rr)
    );

    ipg_tx_frame_arbiter #(
        .N_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .PRIORITY_PORT0(1), .STARVE_LIMIT(4)
    ) dut_pr (
        .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .axis(if_pr.slave), .arb_enable(arb_enable),
        .arb_grant(grant_pr), .arb_busy(busy_pr), .frame_done(done_pr)
    );

    logic          sel;
    logic [NP-1:0] cur_grant, cur_done, cur_sready;
    logic          cur_busy, cur_mvalid, cur_mlast;
    logic [DW-1:0] cur_mdata;

    always_comb begin
        cur_grant  = sel ? grant_pr : grant_rr;
        cur_done   = sel ? done_pr : done_rr;
        cur_busy   = sel ? busy_pr : busy_rr;
        cur_sready = sel ? if_pr.s_axis_tready : if_rr.s_axis_tready;
        cur_mvalid = sel ? if_pr.m_axis_tvalid : if_rr.m_axis_tvalid;
        cur_mlast  = sel ? if_pr.m_axis_tlast : if_rr.m_axis_tlast;
        cur_mdata  = sel ? if_pr.m_axis_tdata : if_rr.m_axis_tdata;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int len [NP];
    int beat [NP];
    int fnum [NP];
    int left [NP];
    logic toggle;
    logic p0_rdy_seen;
    int t;

    logic [NP-1:0] done_log [$];
    int            done_t [$];
    logic [DW-1:0] beat_log [$];
    logic          last_log [$];

    task automatic drive_src();
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p] = (left[p] > 0);
            s_tdata[p*DW +: DW] = {4'(p), 4'(fnum[p]), 8'(beat[p])};
            s_tkeep[p*KW +: KW] = '1;
            s_tlast[p] = (beat[p] == len[p] - 1);
        end
    endtask

    task automatic start_src(input int p, input int l, input int n);
        len[p] = l; beat[p] = 0; fnum[p] = 0; left[p] = n;
        drive_src();
    endtask

    task automatic clear_logs();
        done_log.delete(); done_t.delete(); beat_log.delete(); last_log.delete();
        t = 0;
        p0_rdy_seen = 1'b0;
    endtask

    // One clock: observe at negedge, advance sources just after posedge.
    task automatic cyc();
        logic [NP-1:0] fire;
        @(negedge tx_clk);
        fire = cur_sready & s_tvalid;
        if (cur_done != '0) begin
            done_log.push_back(cur_done);
            done_t.push_back(t);
        end
        if (cur_mvalid && m_tready) begin
            beat_log.push_back(cur_mdata);
            last_log.push_back(cur_mlast);
        end
        if (cur_grant[1]) p0_rdy_seen |= cur_sready[0];
        t++;
        @(posedge tx_clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (fire[p]) begin
                if (beat[p] == len[p] - 1) begin
                    beat[p] = 0; fnum[p]++; left[p]--;
                end else begin
                    beat[p]++;
                end
            end
        end
        if (toggle) m_tready = ~m_tready;
        drive_src();
    endtask

    task automatic do_reset();
        tx_rst_n = 1'b0;
        for (int p = 0; p < NP; p++) begin
            len[p] = 1; beat[p] = 0; fnum[p] = 0; left[p] = 0;
        end
        drive_src();
        m_tready = 1'b1; toggle = 1'b0; arb_enable = 1'b1;
        repeat (2) @(posedge tx_clk);
        #1;
        tx_rst_n = 1'b1;
        clear_logs();
    endtask

    initial begin
        logic [NP-1:0] exp_alt [4];
        logic [NP-1:0] exp_pri [10];
        logic          busy_or;
        exp_alt = '{3'b001, 3'b010, 3'b001, 3'b010};
        exp_pri = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                    3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
        sel = 1'b0; toggle = 1'b0; m_tready = 1'b1; arb_enable = 1'b1;
        for (int p = 0; p < NP; p++) begin
            len[p] = 1; beat[p] = 0; fnum[p] = 0; left[p] = 0;
        end
        tx_rst_n = 1'b1;
        start_src(0, 3, 1);
        #1 tx_rst_n = 1'b0;
        #1;
        chk("rst_grant_rr", grant_rr, 0);
        chk("rst_busy_rr", busy_rr, 0);
        chk("rst_done_rr", done_rr, 0);
        chk("rst_mvalid_rr", if_rr.m_axis_tvalid, 0);
        chk("rst_sready_rr", if_rr.s_axis_tready, 0);
        chk("rst_grant_pr", grant_pr, 0);
        chk("rst_mvalid_pr", if_pr.m_axis_tvalid, 0);

        // Alternating 3-beat frames from ports 0 and 1.
        do_reset();
        sel = 1'b0;
        start_src(0, 3, 2);
        start_src(1, 3, 2);
        for (int i = 0; i < 80 && done_log.size() < 4; i++) cyc();
        chk("alt_frames", done_log.size(), 4);
        chk("alt_beats", beat_log.size(), 12);
        if (done_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("alt_done%0d", i), done_log[i], exp_alt[i]);
                chk($sformatf("alt_time%0d", i), done_t[i], 4 * (i + 1));
            end
        end

        // Port 1 8-beat frame, port 0 requests mid-frame, MAC ready toggling.
        do_reset();
        sel = 1'b0;
        toggle = 1'b1;
        start_src(1, 8, 1);
        for (int i = 0; i < 100 && done_log.size() < 2; i++) begin
            cyc();
            if (beat[1] == 2 && left[1] == 1 && left[0] == 0) start_src(0, 2, 1);
        end
        chk("mid_frames", done_log.size(), 2);
        chk("mid_beats", beat_log.size(), 10);
        chk("mid_p0_ready", p0_rdy_seen, 0);
        if (done_log.size() == 2 && beat_log.size() == 10) begin
            chk("mid_done0", done_log[0], 3'b010);
            chk("mid_done1", done_log[1], 3'b001);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("mid_beat%0d", i), beat_log[i], {4'd1, 4'd0, 8'(i)});
                chk($sformatf("mid_last%0d", i), last_log[i], (i == 7) ? 1 : 0);
            end
            chk("mid_beat8", beat_log[8], {4'd0, 4'd0, 8'd0});
        end
        toggle = 1'b0;

        // Port-0 priority bounded by the starvation limit.
        do_reset();
        sel = 1'b1;
        start_src(0, 2, 20);
        start_src(1, 2, 20);
        for (int i = 0; i < 200 && done_log.size() < 10; i++) cyc();
        chk("pri_frames", done_log.size(), 10);
        if (done_log.size() >= 10) begin
            for (int i = 0; i < 10; i++) chk($sformatf("pri_done%0d", i), done_log[i], exp_pri[i]);
        end
        sel = 1'b0;

        // arb_enable dropped mid-frame.
        do_reset();
        sel = 1'b0;
        start_src(0, 5, 1);
        start_src(1, 2, 5);
        for (int i = 0; i < 50 && done_log.size() < 1; i++) begin
            cyc();
            if (beat[0] == 2 && left[0] == 1) arb_enable = 1'b0;
        end
        chk("en_frames", done_log.size(), 1);
        chk("en_beats", beat_log.size(), 5);
        if (done_log.size() == 1 && beat_log.size() == 5) begin
            chk("en_done", done_log[0], 3'b001);
            chk("en_tlast", last_log[4], 1);
        end
        busy_or = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            busy_or |= cur_busy | (cur_grant != '0);
        end
        chk("en_idle_busy", busy_or, 0);
        chk("en_idle_frames", done_log.size(), 1);
        arb_enable = 1'b1;
        @(negedge tx_clk);
        chk("en_regrant_wait", cur_grant, 3'b000);
        @(negedge tx_clk);
        chk("en_regrant", cur_grant, 3'b010);
        chk("en_regrant_busy", cur_busy, 1);

        // Reset in the middle of a frame.
        do_reset();
        sel = 1'b0;
        start_src(1, 1, 1);
        for (int i = 0; i < 20 && done_log.size() < 1; i++) cyc();
        start_src(2, 6, 1);
        start_src(1, 2, 1);
        for (int i = 0; i < 40 && beat[2] != 3; i++) cyc();
        chk("rstmid_pre_grant", cur_grant, 3'b100);
        chk("rstmid_pre_mvalid", cur_mvalid, 1);
        tx_rst_n = 1'b0;
        #1;
        chk("rstmid_mvalid", cur_mvalid, 0);
        chk("rstmid_grant", cur_grant, 0);
        chk("rstmid_sready", cur_sready, 0);
        @(posedge tx_clk);
        #1;
        tx_rst_n = 1'b1;
        start_src(1, 2, 1);
        start_src(2, 2, 1);
        clear_logs();
        for (int i = 0; i < 20 && done_log.size() < 1; i++) cyc();
        chk("rstmid_first", (done_log.size() > 0) ? done_log[0] : 3'b000, 3'b010);

        // 1-beat frames from port 2.
        do_reset();
        sel = 1'b0;
        start_src(2, 1, 3);
        for (int i = 0; i < 40 && done_log.size() < 3; i++) cyc();
        repeat (4) cyc();
        chk("one_frames", done_log.size(), 3);
        chk("one_beats", beat_log.size(), 3);
        if (done_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("one_done%0d", i), done_log[i], 3'b100);
                chk($sformatf("one_time%0d", i), done_t[i], 2 * (i + 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ipg_tx_frame_arbiter.md
Name: ipg_tx_frame_arbiter

Overview:
- Frame-granular AXI-stream arbiter that shares one MAC+PHY transmit port (the tx_axis_* input of the 10G MAC/PHY wrapper) between N requesters, e.g. host data and control/memory traffic.
- Grants whole frames only, from first beat through tlast, so the MAC never sees interleaved frames.
- Arbitration is round-robin, with an optional strict priority for port 0 that is bounded by a starvation limit.

Parameters:
- N_PORTS, 2, number of requesters (2..8).
- DATA_WIDTH, 64, AXI data width per port.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width per port.
- PRIORITY_PORT0, 0, 1 = port 0 has strict priority at each grant decision.
- STARVE_LIMIT, 4, maximum consecutive port-0 grants while another port waits (PRIORITY_PORT0=1 only); range 1..255.

Ports:
- tx_clk  in  1  transmit clock; all logic is in this domain.
- tx_rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  N_PORTS*DATA_WIDTH  requester data; port i occupies slice i.
- s_axis_tkeep  in  N_PORTS*KEEP_WIDTH  requester byte enables.
- s_axis_tvalid  in  N_PORTS  requester valid.
- s_axis_tready  out  N_PORTS  requester ready.
- s_axis_tlast  in  N_PORTS  requester end of frame.
- m_axis_tdata  out  DATA_WIDTH  to MAC tx_axis_tdata.
- m_axis_tkeep  out  KEEP_WIDTH  to MAC tx_axis_tkeep.
- m_axis_tvalid  out  1  to MAC tx_axis_tvalid.
- m_axis_tready  in  1  from MAC tx_axis_tready.
- m_axis_tlast  out  1  to MAC tx_axis_tlast.
- arb_enable  in  1  0 = issue no new grants; an in-flight frame still completes.
- arb_grant  out  N_PORTS  one-hot registered grant; all zero when idle.
- arb_busy  out  1  high while a frame is in progress (ACTIVE state).
- frame_done  out  N_PORTS  one-cycle pulse on the port whose tlast beat transferred.

Behaviour:
- Reset (tx_rst_n=0, asynchronous):
  - state=IDLE, arb_grant=0, arb_busy=0, frame_done=0.
  - rr_ptr=0, starve_cnt=0.
  - m_axis_tvalid=0, s_axis_tready=0.
- State machine, two states:
  - IDLE: m_axis_tvalid=0, all s_axis_tready=0. If arb_enable and any s_axis_tvalid, choose a winner, register arb_grant, and enter ACTIVE on the next edge. Arbitration latency is 1 cycle.
  - ACTIVE, with winner g:
    - m_axis_tdata/tkeep/tvalid/tlast are combinational from port g, zero added latency.
    - s_axis_tready[g]=m_axis_tready; all other s_axis_tready=0.
    - A beat transfers when m_axis_tvalid & m_axis_tready.
    - On the transfer carrying tlast: next state IDLE, arb_grant cleared, frame_done[g] pulses on the next cycle, rr_ptr <= (g+1) mod N_PORTS.
- Winner selection:
  - Default: first port with tvalid set, searching from rr_ptr upward with wrap.
  - PRIORITY_PORT0=1: port 0 wins if its tvalid is set and starve_cnt<STARVE_LIMIT. Otherwise round-robin as above, with port 0 skipped only when starve_cnt==STARVE_LIMIT and another port is valid.
- starve_cnt update, at each grant:
  - Increments (saturating) when port 0 wins while any other tvalid is high.
  - Clears when any other port wins, or when port 0 wins with no other port valid.
- One idle bubble cycle separates back-to-back frames. This is acceptable because the MAC inserts the IFG anyway.
- A requester that drops tvalid mid-frame keeps the grant; m_axis_tvalid follows it low, and there is no timeout.
- arb_enable falling mid-frame: the frame completes, then the block stays IDLE.
- Single valid port with N_PORTS=1: it is granted every frame, and rr_ptr stays 0.
- tlast on the first beat (1-beat frame): ACTIVE lasts one transfer cycle.
- Reset asserted mid-frame: the grant is dropped immediately. The MAC sees tvalid fall without tlast and flags underflow; this is accepted behaviour.

Test Plan:
- Ports 0 and 1 each send continuous 3-beat frames, PRIORITY_PORT0=0 -> grants alternate 0,1,0,1; frame_done alternates; exactly one bubble cycle between frames.
- Port 1 sends an 8-beat frame while port 0 raises tvalid at beat 2, m_axis_tready toggling 1,0 -> m_axis carries only port-1 beats until its tlast; s_axis_tready[0] stays 0 throughout.
- PRIORITY_PORT0=1, STARVE_LIMIT=4, both ports continuously valid -> grant sequence 0,0,0,0,1,0,0,0,0,1.
- Deassert arb_enable at beat 2 of a 5-beat frame -> frame completes with tlast; arb_busy falls and stays 0 with requests pending; re-enable -> grant issued 1 cycle later.
- Assert tx_rst_n=0 at beat 3 of a frame -> same cycle m_axis_tvalid=0, arb_grant=0, s_axis_tready=0; after release, the first grant goes to the lowest valid port (rr_ptr=0).
- 1-beat frames (tlast on first beat) from port 2 of 3 -> one transfer per frame; frame_done[2] pulses once per frame.
